bch_encoder_lfsr: RTL and testbench
===================================

Name: bch_encoder_lfsr

Overview:
- Systematic binary BCH encoder over GF(2^13). It is the transmit-side counterpart of the syndrome / Euclidean key-equation / Chien decode chain.
- Accepts K message bits DW at a time and passes them through unchanged.
- Divides the message by the generator polynomial g(x) in a DW-bit-parallel LFSR.
- Then emits the N_PAR-bit remainder as parity, MSB first, completing an (K+N_PAR)-bit codeword for the decoder.

Parameters:
- K, 4096, message length in bits; must be a multiple of DW.
- N_PAR, 104, parity length in bits (13*t, t=8); must be a multiple of DW.
- DW, 8, bits per beat on din/dout.
- GEN_POLY, bch_pkg::G_P32_T8, N_PAR low-order coefficients of g(x). The leading x^N_PAR term is implicit; bit i is the coefficient of x^i.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin codeword; honoured only in IDLE
- stop  in  1  synchronous abort; highest priority after reset
- din  in  DW  message bits; din[DW-1] is the earliest (highest-degree) bit
- din_valid  in  1  din qualifier
- din_ready  out  1  encoder accepts din this cycle
- dout  out  DW  codeword bits, registered
- dout_valid  out  1  dout qualifier
- dout_par  out  1  dout beat carries parity
- dout_last  out  1  final beat of codeword
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, LFSR register r[N_PAR-1:0] = 0, state = IDLE, beat counter = 0.
- States are IDLE, MSG and PAR.
- IDLE:
  - din_ready = 0.
  - start -> MSG, r cleared, counter = 0.
- MSG:
  - din_ready = 1.
  - Accept a beat when din_valid && din_ready.
  - Per accepted beat, process bits din[DW-1] down to din[0] serially within the cycle. For each bit b: fb = r[N_PAR-1]^b; r = (r<<1) ^ (fb ? GEN_POLY : 0).
  - Next cycle: dout = din, dout_valid = 1, dout_par = 0.
  - Idle input cycles (din_valid = 0) give dout_valid = 0 and leave r unchanged.
  - After beat K/DW is accepted -> PAR, counter = 0.
- PAR:
  - din_ready = 0.
  - Each cycle: dout <= r[N_PAR-1 -: DW], r <= r<<DW, dout_valid = 1, dout_par = 1.
  - After N_PAR/DW cycles -> IDLE. dout_last = 1 on the final parity beat only.
  - Parity output is unstalled, with no backpressure.
- Latency: each output beat is registered exactly 1 cycle after its input is accepted (message) or the PAR cycle (parity).
- Minimum codeword-to-codeword gap: start in the cycle after the last parity beat is issued gives first message acceptance 1 cycle later.
- start while busy: ignored, no restart.
- stop in any state:
  - Next cycle: IDLE, r = 0, counter = 0, dout_valid = dout_par = dout_last = 0.
  - stop and start in the same cycle: stop wins, state stays IDLE.
- Reset mid-codeword: immediate return to reset values; the partial codeword is lost.
- Counter width is $clog2(max(K,N_PAR)/DW+1); the counter never wraps within a codeword.
- The parity register is cleared only by start, stop or reset, never by drain.

Optional Feature:
- Macro: BCH_ENC_PARITY_INV_EN.
- Defined: parity beats are output as ~r[N_PAR-1 -: DW], so an erased all-ones flash page reads as a valid codeword. Message beats are unaffected. The decoder side must re-invert.
- Undefined: parity is output true.

Decomposition:
- bch_pkg holds the GF(2^13) field width constant (M=13), the T_MAX constant, generator polynomial constants (G_P32_T8, G_BCH15_7 = 8'hD1), and the state enum (IDLE/MSG/PAR).
- One sub-module, bch_lfsr_step: a combinational DW-bit-parallel LFSR next-state function (r, din) -> r_next, reusable by a future syndrome checker.

Test Plan:
- Config K=7, N_PAR=8, DW=1, GEN_POLY=8'hD1 (BCH(15,7)):
  - Message 0000000: parity beats 00000000, dout_last on beat 15.
  - Message 0000001: parity 11010001 (0xD1).
  - Message 1111111: parity 11111111, since the all-ones word is a codeword.
- Default config, random message with din_valid gaps: codeword bits equal golden model message||(m(x)·x^104 mod g(x)). Feeding the codeword to the decoder chain yields zero syndromes; injecting 8 bit errors is corrected.
- stop asserted on message beat 3 of BCH(15,7), then a new start with message 0000001: first codeword is truncated with no parity emitted; second codeword has parity 0xD1, with no residue carried over.
- start pulsed during PAR: ignored, busy stays 1. start in the cycle after dout_last: next codeword is accepted, and the gap between codewords is exactly 1 idle cycle.
- With BCH_ENC_PARITY_INV_EN, message 0000000: parity 11111111, message beats unchanged.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared constants and types for the binary BCH codec over GF(2^13).
package bch_pkg;

    localparam int M     = 13;
    localparam int T_MAX = 8;

    // Low-order coefficients of g(x) for the t=8 code over GF(2^13); x^104 is implicit.
    localparam logic [103:0] G_P32_T8  = 104'hB2F1_3C5A_9E47_D086_1BA3_5C79;
    localparam logic [7:0]   G_BCH15_7 = 8'hD1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2
    } enc_state_e;

endpackage

// File: rtl/bch_lfsr_step.sv
// DW-bit-parallel LFSR next-state for division by g(x); purely combinational.
module bch_lfsr_step
    import bch_pkg::*;
#(
    parameter int                N_PAR    = 104,
    parameter int                DW       = 8,
    parameter logic [N_PAR-1:0]  GEN_POLY = G_P32_T8
) (
    input  logic [N_PAR-1:0] r,
    input  logic [DW-1:0]    din,
    output logic [N_PAR-1:0] r_next
);

    logic [N_PAR-1:0] acc_s;
    logic             fb_s;

    // Unrolled serial division: din[DW-1] is the highest-degree bit, so it goes first.
    always_comb begin
        acc_s = r;
        fb_s  = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            fb_s  = acc_s[N_PAR-1] ^ din[i];
            acc_s = (acc_s << 1) ^ (fb_s ? GEN_POLY : {N_PAR{1'b0}});
        end
        r_next = acc_s;
    end

endmodule

// File: rtl/bch_encoder_lfsr.sv
// Systematic BCH encoder: message pass-through, then N_PAR parity bits MSB first.
// Optional build macro BCH_ENC_PARITY_INV_EN inverts parity beats on output.
module bch_encoder_lfsr
    import bch_pkg::*;
#(
    parameter int                K        = 4096,
    parameter int                N_PAR    = 104,
    parameter int                DW       = 8,
    parameter logic [N_PAR-1:0]  GEN_POLY = G_P32_T8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          dout_par,
    output logic          dout_last,
    output logic          busy
);

    localparam int MAX_LEN = (K > N_PAR) ? K : N_PAR;
    localparam int CNT_W   = $clog2(MAX_LEN / DW + 1);
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(K / DW - 1);
    localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(N_PAR / DW - 1);

    enc_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N_PAR-1:0] lfsr_r;
    logic [N_PAR-1:0] lfsr_next_s;
    logic [DW-1:0]    par_beat_s;
    logic [DW-1:0]    dout_r;
    logic             dout_valid_r;
    logic             dout_par_r;
    logic             dout_last_r;
    logic             din_ready_r;
    logic             busy_r;

    bch_lfsr_step #(
        .N_PAR    (N_PAR),
        .DW       (DW),
        .GEN_POLY (GEN_POLY)
    ) u_step (
        .r      (lfsr_r),
        .din    (din),
        .r_next (lfsr_next_s)
    );

`ifdef BCH_ENC_PARITY_INV_EN
    assign par_beat_s = ~lfsr_r[N_PAR-1 -: DW];
`else
    assign par_beat_s = lfsr_r[N_PAR-1 -: DW];
`endif

    // Encoder FSM with all outputs registered; stop overrides everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            lfsr_r       <= {N_PAR{1'b0}};
            dout_r       <= {DW{1'b0}};
            dout_valid_r <= 1'b0;
            dout_par_r   <= 1'b0;
            dout_last_r  <= 1'b0;
            din_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else if (stop) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            lfsr_r       <= {N_PAR{1'b0}};
            dout_r       <= {DW{1'b0}};
            dout_valid_r <= 1'b0;
            dout_par_r   <= 1'b0;
            dout_last_r  <= 1'b0;
            din_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    dout_valid_r <= 1'b0;
                    dout_par_r   <= 1'b0;
                    dout_last_r  <= 1'b0;
                    if (start) begin
                        state_r     <= MSG;
                        cnt_r       <= {CNT_W{1'b0}};
                        lfsr_r      <= {N_PAR{1'b0}};
                        din_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        din_ready_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                MSG: begin
                    dout_par_r  <= 1'b0;
                    dout_last_r <= 1'b0;
                    if (din_valid) begin
                        dout_r       <= din;
                        dout_valid_r <= 1'b1;
                        lfsr_r       <= lfsr_next_s;
                        if (cnt_r == MSG_LAST) begin
                            state_r     <= PAR;
                            cnt_r       <= {CNT_W{1'b0}};
                            din_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        dout_valid_r <= 1'b0;
                    end
                end
                PAR: begin
                    // Drain shifts the register; it is not cleared here.
                    dout_r       <= par_beat_s;
                    lfsr_r       <= lfsr_r << DW;
                    dout_valid_r <= 1'b1;
                    dout_par_r   <= 1'b1;
                    if (cnt_r == PAR_LAST) begin
                        state_r     <= IDLE;
                        cnt_r       <= {CNT_W{1'b0}};
                        dout_last_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        cnt_r       <= cnt_r + CNT_W'(1);
                        dout_last_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= {CNT_W{1'b0}};
                    lfsr_r       <= {N_PAR{1'b0}};
                    dout_valid_r <= 1'b0;
                    dout_par_r   <= 1'b0;
                    dout_last_r  <= 1'b0;
                    din_ready_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready  = din_ready_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign dout_par   = dout_par_r;
    assign dout_last  = dout_last_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_bch_encoder_lfsr.sv
// Bench: BCH(15,7) bit-serial instance plus the default 4096+104 byte-wide instance.
module tb_bch_encoder_lfsr;
    import bch_pkg::*;

    localparam int SK = 7;
    localparam int SN = 8;
    localparam int BK = 4096;
    localparam int BN = 104;
    localparam int BW = 8;

    typedef struct packed {
        logic       last;
        logic       par;
        logic [7:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s_start = 1'b0, s_stop = 1'b0, s_din_valid = 1'b0;
    logic [0:0] s_din = 1'b0;
    logic       s_din_ready, s_dout_valid, s_dout_par, s_dout_last, s_busy;
    logic [0:0] s_dout;

    logic          b_start = 1'b0, b_stop = 1'b0, b_din_valid = 1'b0;
    logic [BW-1:0] b_din = 8'h00;
    logic          b_din_ready, b_dout_valid, b_dout_par, b_dout_last, b_busy;
    logic [BW-1:0] b_dout;

    bch_encoder_lfsr #(.K(SK), .N_PAR(SN), .DW(1), .GEN_POLY(G_BCH15_7)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop),
        .din(s_din), .din_valid(s_din_valid), .din_ready(s_din_ready),
        .dout(s_dout), .dout_valid(s_dout_valid), .dout_par(s_dout_par),
        .dout_last(s_dout_last), .busy(s_busy)
    );

    bch_encoder_lfsr u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop),
        .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .dout(b_dout), .dout_valid(b_dout_valid), .dout_par(b_dout_par),
        .dout_last(b_dout_last), .busy(b_busy)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    beat_t s_got[$], s_exp[$], b_got[$], b_exp[$];
    int    s_stamp[$];

    // Collect every valid output beat away from the rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (s_dout_valid) begin
            s_got.push_back({s_dout_last, s_dout_par, 7'd0, s_dout});
            s_stamp.push_back(cyc);
        end
        if (b_dout_valid) begin
            b_got.push_back({b_dout_last, b_dout_par, b_dout});
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: long division of m(x)*x^n by g(x), bits MSB first.
    function automatic logic [103:0] ref_parity(input int k, input int n,
                                                input logic [104:0] g_full, input bit msg[]);
        bit w[];
        logic [103:0] rem;
        w = new[k + n];
        for (int i = 0; i < k; i++) w[i] = msg[i];
        for (int i = 0; i < k; i++) begin
            if (w[i]) begin
                for (int j = 0; j <= n; j++) w[i + j] = w[i + j] ^ g_full[n - j];
            end
        end
        rem = 104'd0;
        for (int i = 0; i < n; i++) rem[n - 1 - i] = w[k + i];
        return rem;
    endfunction

    function automatic logic [103:0] out_par(input logic [103:0] p);
`ifdef BCH_ENC_PARITY_INV_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic compare_q(input string tag, input beat_t got[$], input beat_t exp[$]);
        check_eq({tag, "_count"}, 128'(got.size()), 128'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check_eq($sformatf("%s_beat%0d", tag, i), 128'(got[i]), 128'(exp[i]));
    endtask

    task automatic s_clear();
        s_got.delete(); s_exp.delete(); s_stamp.delete();
    endtask

    task automatic s_expect(input logic [6:0] msg, input int n_msg, input bit with_par);
        bit m[];
        logic [103:0] p;
        m = new[SK];
        for (int i = 0; i < n_msg; i++) s_exp.push_back({1'b0, 1'b0, 7'd0, msg[6 - i]});
        if (with_par) begin
            for (int i = 0; i < SK; i++) m[i] = msg[6 - i];
            p = out_par(ref_parity(SK, SN, 105'(G_BCH15_7) | (105'd1 << SN), m));
            for (int i = 0; i < SN; i++)
                s_exp.push_back({(i == SN - 1), 1'b1, 7'd0, p[SN - 1 - i]});
        end
    endtask

    // Parity bits from the collected small-instance beats, packed MSB first.
    function automatic logic [7:0] s_par_bits();
        logic [7:0] v = 8'd0;
        for (int i = 0; i < s_got.size(); i++)
            if (s_got[i].par) v = {v[6:0], s_got[i].data[0]};
        return v;
    endfunction

    task automatic s_send(input logic [6:0] msg, input int stop_at);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int b = 0; b < SK; b++) begin
            s_din = msg[6 - b];
            s_din_valid = 1'b1;
            s_stop = (b == stop_at);
            @(negedge clk);
            if (b == stop_at) begin
                s_stop = 1'b0;
                s_din_valid = 1'b0;
                check_eq("stop_busy", 128'(s_busy), 128'd0);
                check_eq("stop_valid", 128'(s_dout_valid), 128'd0);
                break;
            end
        end
        s_din_valid = 1'b0;
        s_stop = 1'b0;
    endtask

    task automatic s_wait_idle();
        int t = 0;
        while (s_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("s_idle_in_time", 128'(s_busy), 128'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic s_run(input string tag, input logic [6:0] msg, input logic [7:0] par_lit);
        s_clear();
        s_send(msg, -1);
        s_wait_idle();
        s_expect(msg, SK, 1'b1);
        compare_q(tag, s_got, s_exp);
        check_eq({tag, "_par"}, 128'(s_par_bits()), 128'(par_lit));
    endtask

    task automatic b_run(input string tag, input int mode);
        bit m[];
        logic [BW-1:0] bt;
        logic [103:0] p;
        int beat = 0;
        int t = 0;
        m = new[BK];
        for (int i = 0; i < BK; i++) m[i] = (mode == 0) ? 1'b0 : bit'($urandom_range(0, 1));
        b_got.delete(); b_exp.delete();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check_eq({tag, "_ready"}, 128'(b_din_ready), 128'd1);
        while (beat < BK / BW) begin
            if ($urandom_range(0, 3) == 0) begin
                b_din_valid = 1'b0;
            end else begin
                for (int i = 0; i < BW; i++) bt[BW - 1 - i] = m[beat * BW + i];
                b_din = bt;
                b_din_valid = 1'b1;
                beat++;
            end
            @(negedge clk);
        end
        b_din_valid = 1'b0;
        check_eq({tag, "_ready_par"}, 128'(b_din_ready), 128'd0);
        while (b_busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_idle_in_time"}, 128'(b_busy), 128'd0);
        @(negedge clk);
        @(negedge clk);
        for (int j = 0; j < BK / BW; j++) begin
            for (int i = 0; i < BW; i++) bt[BW - 1 - i] = m[j * BW + i];
            b_exp.push_back({1'b0, 1'b0, bt});
        end
        p = out_par(ref_parity(BK, BN, {1'b1, G_P32_T8}, m));
        for (int j = 0; j < BN / BW; j++)
            b_exp.push_back({(j == BN / BW - 1), 1'b1, p[103 - BW * j -: BW]});
        compare_q(tag, b_got, b_exp);
    endtask

    initial begin
        logic [7:0] par_zero;
        logic [7:0] par_d1;
        logic [7:0] par_ones;
        logic [7:0] p_tmp;
`ifdef BCH_ENC_PARITY_INV_EN
        par_zero = 8'hFF; par_d1 = 8'h2E; par_ones = 8'h00;
`else
        par_zero = 8'h00; par_d1 = 8'hD1; par_ones = 8'hFF;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_s_out", 128'({s_dout, s_dout_valid, s_dout_par, s_dout_last, s_busy, s_din_ready}), 128'd0);
        check_eq("rst_b_out", 128'({b_dout, b_dout_valid, b_dout_par, b_dout_last, b_busy, b_din_ready}), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        s_run("m0000000", 7'b0000000, par_zero);
        check_eq("m0_last_beat15", 128'(s_got.size() == 15 && s_got[14].last), 128'd1);
        s_run("m0000001", 7'b0000001, par_d1);
        s_run("m1111111", 7'b1111111, par_ones);

        // Abort mid-message, then a fresh codeword must carry no residue.
        s_clear();
        s_send(7'b1011011, 3);
        repeat (4) @(negedge clk);
        s_expect(7'b1011011, 3, 1'b0);
        compare_q("stop_trunc", s_got, s_exp);
        s_run("after_stop", 7'b0000001, par_d1);

        // start during PAR is ignored.
        s_clear();
        s_send(7'b1010011, -1);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check_eq("start_in_par_busy", 128'(s_busy), 128'd1);
        @(negedge clk);
        check_eq("start_in_par_busy2", 128'(s_busy), 128'd1);
        s_wait_idle();
        s_expect(7'b1010011, SK, 1'b1);
        compare_q("start_in_par", s_got, s_exp);

        // Back-to-back codewords: start while dout_last is showing.
        s_clear();
        s_send(7'b0110101, -1);
        begin
            int t = 0;
            while (!s_dout_last && t < 50) begin
                @(negedge clk);
                t++;
            end
            check_eq("b2b_last_seen", 128'(s_dout_last), 128'd1);
        end
        s_send(7'b0000001, -1);
        s_wait_idle();
        s_expect(7'b0110101, SK, 1'b1);
        s_expect(7'b0000001, SK, 1'b1);
        compare_q("b2b", s_got, s_exp);
        if (s_stamp.size() == 30)
            check_eq("b2b_gap", 128'(s_stamp[15] - s_stamp[14] - 1), 128'd1);
        else
            check_eq("b2b_stamps", 128'(s_stamp.size()), 128'd30);

        // Reset mid-codeword.
        s_clear();
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_din = 1'b1;
        s_din_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out", 128'({s_dout_valid, s_dout_par, s_dout_last, s_busy, s_din_ready}), 128'd0);
        s_din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s_run("after_rst", 7'b0000001, par_d1);

        // Wide instance: all-zero message, then random messages with input gaps.
        b_run("big_zero", 0);
        p_tmp = b_got.size() > 512 ? b_got[512].data : 8'h5A;
        check_eq("big_zero_par0", 128'(p_tmp), 128'(par_zero));
        for (int r = 0; r < 3; r++) b_run($sformatf("big_rand%0d", r), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
